// File: rtl/ofm_maxpool2x2_if.sv
// Bundle between the 2x2 max-pool block, the OFM FIFO read port and the downstream stage.
// master is the pooling block's view; slave is the surrounding FIFO/consumer view.
interface ofm_maxpool2x2_if #(
  parameter int DATA_WIDTH = 16
);
  logic                         start;
  logic                         fifo_empty;
  logic                         fifo_rd_en;
  logic signed [DATA_WIDTH-1:0] fifo_data;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic                         out_valid;
  logic                         out_ready;
  logic                         busy;
  logic                         done;

  modport master (
    input  start, fifo_empty, fifo_data, out_ready,
    output fifo_rd_en, out_data, out_valid, busy, done
  );

  modport slave (
    output start, fifo_empty, fifo_data, out_ready,
    input  fifo_rd_en, out_data, out_valid, busy, done
  );
endinterface

// File: rtl/ofm_maxpool2x2.sv
// 2x2/stride-2 signed max pooling over a row-major OFM stream read from a FIFO with
// 1-cycle read latency; a half-row line buffer carries even-row pair maxima.
module ofm_maxpool2x2 #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_W      = 416,
  parameter int IMG_H      = 416
) (
  input  logic             clk,
  input  logic             rst_n,
  ofm_maxpool2x2_if.master bus
);
  localparam int NPIX = IMG_W * IMG_H;
  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = $clog2(IMG_H);
  localparam int RCW  = $clog2(NPIX + 1);
  localparam int LBN  = IMG_W / 2;
  localparam int LBW  = (LBN > 1) ? $clog2(LBN) : 1;
  localparam logic [CW-1:0]  COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0]  ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RCW-1:0] RD_TOTAL = RCW'(NPIX);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

  state_e                       state_q, state_d;
  logic [RCW-1:0]               rd_cnt_q;
  logic [CW-1:0]                icol_q, col_q;
  logic [RW-1:0]                irow_q, row_q;
  logic                         rvld_q, rprod_q;
  logic [1:0]                   q_cnt_q;
  logic signed [DATA_WIDTH-1:0] q0_q, q1_q, prev_q;
  logic signed [DATA_WIDTH-1:0] linebuf_q [LBN];

  logic                         rd_en, this_prod, pop, push, credit_ok, start_ok, done;
  logic [2:0]                   need;
  logic [LBW-1:0]               lb_idx;
  logic signed [DATA_WIDTH-1:0] pair_max, pool_max;

  function automatic logic signed [DATA_WIDTH-1:0] smax(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  // Issue side: a read "produces" when it lands on an odd row and odd column.
  assign start_ok  = (state_q == IDLE) && bus.start;
  assign pop       = (q_cnt_q != 2'd0) && bus.out_ready;
  assign this_prod = icol_q[0] & irow_q[0];
  assign need      = 3'(q_cnt_q) + 3'(rvld_q & rprod_q) + 3'(this_prod);
  assign credit_ok = need <= (3'd2 + 3'(pop));
  assign rd_en     = (state_q == RUN) && !bus.fifo_empty && (rd_cnt_q < RD_TOTAL) && credit_ok;

  assign lb_idx    = LBW'(col_q >> 1);
  assign pair_max  = smax(prev_q, bus.fifo_data);
  assign pool_max  = smax(linebuf_q[lb_idx], pair_max);
  assign push      = rvld_q && col_q[0] && row_q[0];

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      IDLE:  if (bus.start) state_d = RUN;
      RUN:   if (rd_cnt_q == RD_TOTAL) state_d = FLUSH;
      FLUSH: if (!rvld_q && (q_cnt_q == 2'd0)) begin
               state_d = IDLE;
               done    = 1'b1;
             end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rd_cnt_q <= '0;
      icol_q   <= '0;
      irow_q   <= '0;
      col_q    <= '0;
      row_q    <= '0;
      rvld_q   <= 1'b0;
      rprod_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rvld_q  <= rd_en;
      rprod_q <= rd_en & this_prod;
      if (start_ok) begin
        rd_cnt_q <= '0;
        icol_q   <= '0;
        irow_q   <= '0;
        col_q    <= '0;
        row_q    <= '0;
      end else begin
        if (rd_en) begin
          rd_cnt_q <= rd_cnt_q + RCW'(1);
          if (icol_q == COL_LAST) begin
            icol_q <= '0;
            irow_q <= (irow_q == ROW_LAST) ? '0 : irow_q + RW'(1);
          end else begin
            icol_q <= icol_q + CW'(1);
          end
        end
        if (rvld_q) begin
          if (col_q == COL_LAST) begin
            col_q <= '0;
            row_q <= (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
          end else begin
            col_q <= col_q + CW'(1);
          end
        end
      end
    end
  end

  // Two-entry output queue; q0 is the head presented downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_cnt_q <= 2'd0;
      q0_q    <= '0;
      q1_q    <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (q_cnt_q == 2'd0) q0_q <= pool_max;
          else                 q1_q <= pool_max;
          q_cnt_q <= q_cnt_q + 2'd1;
        end
        2'b01: begin
          q0_q    <= q1_q;
          q_cnt_q <= q_cnt_q - 2'd1;
        end
        2'b11: begin
          if (q_cnt_q == 2'd1) begin
            q0_q <= pool_max;
          end else begin
            q0_q <= q1_q;
            q1_q <= pool_max;
          end
        end
        default: ;
      endcase
    end
  end

  // Pairing datapath; the line buffer is always written on an even row before it is read.
  always_ff @(posedge clk) begin
    if (rvld_q) begin
      if (!col_q[0])      prev_q            <= bus.fifo_data;
      else if (!row_q[0]) linebuf_q[lb_idx] <= pair_max;
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.out_data   = q0_q;
  assign bus.out_valid  = (q_cnt_q != 2'd0);
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done;
endmodule

// File: tb/tb_ofm_maxpool2x2.sv
// Directed bench for ofm_maxpool2x2: a 4x4 instance driven from a vector table plus
// hand sequences, and an 8x4 instance with random data and random downstream stalls.
module tb_ofm_maxpool2x2;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ofm_maxpool2x2_if #(.DATA_WIDTH(16)) ifa ();
  ofm_maxpool2x2_if #(.DATA_WIDTH(16)) ifb ();

  ofm_maxpool2x2 #(.DATA_WIDTH(16), .IMG_W(4), .IMG_H(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.master));
  ofm_maxpool2x2 #(.DATA_WIDTH(16), .IMG_W(8), .IMG_H(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.master));

  typedef struct {
    int kind;
    bit gaps;
    int stall;
    bit restart;
    int exp[4];
  } vec_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus controls and FIFO models
  logic start_a, start_b, rdy_a, rdy_b, gap_a, gap_b, clr_a, clr_b;
  logic signed [15:0] mem_a [16];
  logic signed [15:0] mem_b [32];
  int len_a = 0, len_b = 0, rd_a = 0, rd_b = 0;

  assign ifa.start      = start_a;
  assign ifb.start      = start_b;
  assign ifa.out_ready  = rdy_a;
  assign ifb.out_ready  = rdy_b;
  assign ifa.fifo_empty = (rd_a >= len_a) || gap_a;
  assign ifb.fifo_empty = (rd_b >= len_b) || gap_b;

  always @(posedge clk) begin
    if (clr_a) rd_a <= 0;
    else if (ifa.fifo_rd_en && !ifa.fifo_empty) begin
      ifa.fifo_data <= mem_a[rd_a[3:0]];
      rd_a <= rd_a + 1;
    end
  end

  always @(posedge clk) begin
    if (clr_b) rd_b <= 0;
    else if (ifb.fifo_rd_en && !ifb.fifo_empty) begin
      ifb.fifo_data <= mem_b[rd_b[4:0]];
      rd_b <= rd_b + 1;
    end
  end

  // Output monitors, sampled on the falling edge
  int got_a[$];
  int got_b[$];
  int done_a = 0, done_b = 0, viol_a = 0, viol_b = 0;
  int acc_cyc_a = 0, done_cyc_a = 0, rd_cyc_a = 0;
  logic stall_a = 1'b0, stall_b = 1'b0;
  logic signed [15:0] hold_a = '0, hold_b = '0;

  always @(negedge clk) begin
    if (ifa.out_valid && ifa.out_ready) begin
      got_a.push_back(int'(ifa.out_data));
      acc_cyc_a <= cyc;
    end
    if (ifa.done) begin
      done_a     <= done_a + 1;
      done_cyc_a <= cyc;
    end
    if (ifa.fifo_rd_en) rd_cyc_a <= cyc;
    if ((ifa.fifo_rd_en && ifa.fifo_empty) ||
        (stall_a && !(ifa.out_valid && (ifa.out_data == hold_a))))
      viol_a <= viol_a + 1;
    stall_a <= ifa.out_valid && !ifa.out_ready;
    hold_a  <= ifa.out_data;
  end

  always @(negedge clk) begin
    if (ifb.out_valid && ifb.out_ready) got_b.push_back(int'(ifb.out_data));
    if (ifb.done) done_b <= done_b + 1;
    if ((ifb.fifo_rd_en && ifb.fifo_empty) || (dut_b.q_cnt_q > 2'd2) ||
        (stall_b && !(ifb.out_valid && (ifb.out_data == hold_b))))
      viol_b <= viol_b + 1;
    stall_b <= ifb.out_valid && !ifb.out_ready;
    hold_b  <= ifb.out_data;
  end

  task automatic check(input string nm, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  function automatic logic signed [15:0] pat(input int kind, input int i);
    case (kind)
      0:       return 16'(i);
      1:       return 16'(-i);
      2:       return 16'(15 - i);
      3:       return (i % 2 == 1) ? 16'(-i * 100) : 16'(i);
      default: return (i == 10) ? 16'sh7FFF : 16'sh8000;
    endcase
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  function automatic vec_t mk(input int k, input bit g, input int s, input bit r,
                              input int e0, input int e1, input int e2, input int e3);
    vec_t v;
    v.kind = k; v.gaps = g; v.stall = s; v.restart = r;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
    return v;
  endfunction

  task automatic load_a(input int kind);
    for (int i = 0; i < 16; i++) mem_a[i] = pat(kind, i);
    len_a = 16;
    clr_a = 1'b1;
    @(posedge clk); #1;
    clr_a = 1'b0;
  endtask

  task automatic run_frame(input bit sel, input bit gaps, input int stall, input bit restart,
                           output bit tmo);
    int budget;
    int d0;
    bit g, r;
    d0 = sel ? done_b : done_a;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    budget = 0;
    while (((sel ? done_b : done_a) == d0) && (budget < 3000)) begin
      g = gaps && (cyc % 3 == 0);
      r = (stall == 0) || ($urandom_range(0, 99) >= stall);
      if (sel) begin gap_b = g; rdy_b = r; end
      else begin
        gap_a   = g;
        rdy_a   = r;
        start_a = restart && (budget == 5);
      end
      @(posedge clk); #1;
      budget++;
    end
    gap_a = 1'b0; gap_b = 1'b0; rdy_a = 1'b1; rdy_b = 1'b1; start_a = 1'b0;
    tmo = (budget >= 3000);
    repeat (4) @(posedge clk);
    #1;
  endtask

  vec_t vecs[7];
  int   n0, d0, v0, val;
  bit   tmo;
  int   exp_b[8];

  initial begin
    rst_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; rdy_a = 1'b1; rdy_b = 1'b1;
    gap_a = 1'b0; gap_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;

    vecs[0] = mk(0, 0, 0,  0, 5, 7, 13, 15);
    vecs[1] = mk(1, 0, 0,  0, 0, -2, -8, -10);
    vecs[2] = mk(0, 1, 0,  0, 5, 7, 13, 15);
    vecs[3] = mk(2, 0, 30, 0, 15, 13, 7, 5);
    vecs[4] = mk(3, 1, 30, 0, 4, 6, 12, 14);
    vecs[5] = mk(4, 0, 0,  0, -32768, -32768, -32768, 32767);
    vecs[6] = mk(0, 0, 0,  1, 5, 7, 13, 15);

    repeat (3) @(posedge clk);
    #1;
    check("reset rd_en", int'(ifa.fifo_rd_en), 0);
    check("reset out_valid", int'(ifa.out_valid), 0);
    check("reset out_data", int'(ifa.out_data), 0);
    check("reset busy", int'(ifa.busy), 0);
    check("reset done", int'(ifa.done), 0);
    check("reset busy_b", int'(ifb.busy), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 7; v++) begin
      load_a(vecs[v].kind);
      n0 = got_a.size(); d0 = done_a; v0 = viol_a;
      run_frame(1'b0, vecs[v].gaps, vecs[v].stall, vecs[v].restart, tmo);
      check($sformatf("v%0d timeout", v), int'(tmo), 0);
      for (int k = 0; k < 4; k++) begin
        val = (n0 + k < got_a.size()) ? got_a[n0 + k] : 32'h7FFF_FFFF;
        check($sformatf("v%0d out%0d", v, k), val, vecs[v].exp[k]);
      end
      check($sformatf("v%0d out count", v), got_a.size() - n0, 4);
      check($sformatf("v%0d done count", v), done_a - d0, 1);
      check($sformatf("v%0d reads", v), rd_a, 16);
      check($sformatf("v%0d protocol", v), viol_a - v0, 0);
      check($sformatf("v%0d done delay", v), done_cyc_a - acc_cyc_a, 1);
      if (vecs[v].stall == 0)
        check($sformatf("v%0d latency", v), acc_cyc_a - rd_cyc_a, 2);
    end

    // Asynchronous reset after six reads, then a clean frame
    load_a(0);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int b = 0; (b < 200) && (rd_a < 6); b++) begin
      @(posedge clk); #1;
    end
    check("midrst reads", rd_a, 6);
    rst_n = 1'b0;
    #1;
    check("midrst rd_en", int'(ifa.fifo_rd_en), 0);
    check("midrst out_valid", int'(ifa.out_valid), 0);
    check("midrst out_data", int'(ifa.out_data), 0);
    check("midrst busy", int'(ifa.busy), 0);
    check("midrst done", int'(ifa.done), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    load_a(0);
    n0 = got_a.size(); d0 = done_a;
    run_frame(1'b0, 1'b0, 0, 1'b0, tmo);
    check("postrst timeout", int'(tmo), 0);
    for (int k = 0; k < 4; k++) begin
      val = (n0 + k < got_a.size()) ? got_a[n0 + k] : 32'h7FFF_FFFF;
      check($sformatf("postrst out%0d", k), val, 5 + 2 * (k % 2) + 8 * (k / 2));
    end
    check("postrst out count", got_a.size() - n0, 4);
    check("postrst done count", done_a - d0, 1);

    // 8x4 random frame with random downstream stalls
    for (int i = 0; i < 32; i++) mem_b[i] = 16'($urandom);
    for (int br = 0; br < 2; br++)
      for (int bc = 0; bc < 4; bc++)
        exp_b[br * 4 + bc] = max4(int'(mem_b[(2 * br) * 8 + 2 * bc]),
                                  int'(mem_b[(2 * br) * 8 + 2 * bc + 1]),
                                  int'(mem_b[(2 * br + 1) * 8 + 2 * bc]),
                                  int'(mem_b[(2 * br + 1) * 8 + 2 * bc + 1]));
    len_b = 32;
    clr_b = 1'b1;
    @(posedge clk); #1;
    clr_b = 1'b0;
    n0 = got_b.size(); d0 = done_b; v0 = viol_b;
    run_frame(1'b1, 1'b0, 30, 1'b0, tmo);
    check("rand timeout", int'(tmo), 0);
    for (int k = 0; k < 8; k++) begin
      val = (n0 + k < got_b.size()) ? got_b[n0 + k] : 32'h7FFF_FFFF;
      check($sformatf("rand out%0d", k), val, exp_b[k]);
    end
    check("rand out count", got_b.size() - n0, 8);
    check("rand done count", done_b - d0, 1);
    check("rand reads", rd_b, 32);
    check("rand protocol", viol_b - v0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ofm_maxpool2x2.md
# ofm_maxpool2x2

Downstream consumer of the layer-1 OFM FIFO: reads one channel's convolution output as a row-major stream of IMG_W×IMG_H signed samples and produces the 2×2/stride-2 max-pooled map, (IMG_W/2)×(IMG_H/2) samples in row-major order. It drives the FIFO's read enable, absorbs the FIFO's 1-cycle registered read latency and honours a valid/ready handshake toward the next stage. A half-row line buffer holds horizontal pair maxima from even rows.

## Interface
- DATA_WIDTH, 16, sample width, signed two's complement
- IMG_W, 416, input row length; even, ≥2
- IMG_H, 416, input row count; even, ≥2
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse, begins a frame; ignored unless IDLE
- fifo_empty  in  1  OFM FIFO empty flag
- fifo_rd_en  out  1  OFM FIFO read request
- fifo_data  in  DATA_WIDTH  FIFO output, valid the cycle after an accepted read
- out_data  out  DATA_WIDTH  pooled sample
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts when out_valid & out_ready
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at frame completion

## Operation
- FSM states: IDLE, RUN, FLUSH.
  - IDLE→RUN on start; clear rd_cnt, row and col counters.
  - RUN→FLUSH once IMG_W·IMG_H reads have issued.
  - FLUSH→IDLE when no read is in flight and the output queue is empty; done=1 for exactly that transition cycle.
- Read issue: fifo_rd_en = RUN & !fifo_empty & (rd_cnt < IMG_W·IMG_H) & credit_ok. Each asserted fifo_rd_en is one accepted read, so rd_cnt increments.
- Sample tracking: one read-valid flag delayed by 1 cycle marks fifo_data as valid. col (0..IMG_W-1) and row (0..IMG_H-1) advance per valid sample; col wraps to 0 and row increments at IMG_W-1.
- Even col: capture sample into prev register.
- Odd col, even row: linebuf[col>>1] ← max(prev, sample).
- Odd col, odd row: result = max(linebuf[col>>1], prev, sample); push into output queue.
- Line buffer: IMG_W/2 entries of DATA_WIDTH. Never cleared; every entry is written before it is read.
- Comparisons are signed; ties are irrelevant because the value is identical.
- Output queue: 2 entries; head drives out_data/out_valid; pop on out_valid & out_ready.
- Credit: a read is "producing" if it will land at odd row, odd col. credit_ok = (q_count − pop_this_cycle + producing_reads_in_flight + this_read_producing) ≤ 2. The queue can therefore never overflow.
- Output count per frame: (IMG_W/2)·(IMG_H/2); 43264 at defaults.
- Counter widths: col $clog2(IMG_W), row $clog2(IMG_H), rd_cnt $clog2(IMG_W·IMG_H+1).

## Timing
- Reset values: fifo_rd_en=0, out_valid=0, out_data=0, busy=0, done=0. FSM=IDLE, all counters 0, queue empty, in-flight flag 0.
- fifo_rd_en is combinational from registered state and fifo_empty/out_ready. No read is ever issued while fifo_empty=1.
- Latency: read of bottom-right pixel at cycle t; fifo_data at t+1; out_valid with result at t+2.
- Throughput: 1 input sample/cycle when FIFO is non-empty and out_ready=1.
- out_data and out_valid stay stable while out_valid & !out_ready.
- Simultaneous push and pop: q_count unchanged, order preserved.
- FIFO empty mid-row: reads pause; col/row/prev/linebuf state holds. No bubble may corrupt pairing.
- start while busy: ignored, no state change.
- Async reset mid-frame: return to reset values immediately. Partial frame discarded; next start begins a fresh frame.
- done is asserted only after the last pooled sample has been accepted.

## Test plan
- IMG_W=4, IMG_H=4, FIFO preloaded 0..15, out_ready=1 → outputs 5, 7, 13, 15 in order; done one cycle after the 15 is accepted; 16 reads total.
- Same frame with values negated (0, −1, …, −15) → outputs 0, −2, −8, −10, confirming signed compare.
- IMG_W=8, IMG_H=4, random data, out_ready toggled by random 30% stalls → 8 outputs matching the golden model; out_data stable during stalls; queue never exceeds 2.
- FIFO empty injected every 3rd cycle mid-row → same results as the no-gap run; fifo_rd_en never high while fifo_empty=1.
- start pulsed again during RUN → ignored; exactly 4 outputs and one done for a 4×4 frame.
- rst_n asserted after 6 reads of a 4×4 frame → all outputs 0 on that edge; a subsequent start with a fresh 0..15 frame gives 5, 7, 13, 15.
